// File: rtl/fpu_ex_issue.sv
// fpu_ex_issue: issues one FPU operation at a time to an FPU slave.
// It holds the command stable while the slave reports HOLD and turns
// an OK result into a one-cycle registered writeback. A slave FAULT,
// or more than TIMEOUT consecutive HOLDs, parks the block in FAULT
// until flush.
//
// Handshake: an op transfers on a rising edge where reqValid && reqReady.
// reqReady depends only on state and flush, never on reqValid.
// reqValid may be raised or dropped freely. The request fields are
// sampled only on the transfer edge.
module fpu_ex_issue #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [7:0]  reqCmd,
  input  logic [7:0]  reqIxt,
  input  logic [17:0] reqIds,
  input  logic [63:0] reqValRs,
  input  logic [63:0] reqValRt,
  output logic [7:0]  fpuOpCmd,
  output logic [7:0]  fpuIdIxt,
  output logic [17:0] fpuIds,
  output logic [63:0] fpuValRs,
  output logic [63:0] fpuValRt,
  input  logic [1:0]  fpuOutOK,
  input  logic [5:0]  fpuOutId,
  input  logic [63:0] fpuOutVal,
  input  logic        fpuOutSrT,
  output logic        wbValid,
  output logic [5:0]  wbId,
  output logic [63:0] wbVal,
  output logic        wbSrT,
  input  logic        flush,
  output logic        fault,
  output logic [1:0]  dbgState
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBusy  = 2'd1;
  localparam logic [1:0] StFault = 2'd2;

  localparam logic [1:0] OkReady = 2'd0;
  localparam logic [1:0] OkOk    = 2'd1;
  localparam logic [1:0] OkHold  = 2'd2;
  localparam logic [1:0] OkFault = 2'd3;

  // The NOP shown to the slave when nothing is issued (NV condition, opcode 0)
  localparam logic [7:0] NopCmd = 8'h40;
  localparam logic [3:0] TimeoutCnt = 4'(TIMEOUT);

  logic [1:0]  state;
  logic [1:0]  stateNext;
  logic [3:0]  holdCnt;
  logic [7:0]  cmdQ;
  logic [7:0]  ixtQ;
  logic [17:0] idsQ;
  logic [63:0] valRsQ;
  logic [63:0] valRtQ;
  logic        accept;
  logic        busy;
  logic        wbFire;

  assign busy     = (state == StBusy);
  assign reqReady = (state == StIdle) && !flush;
  assign accept   = reqValid && reqReady;
  assign fault    = (state == StFault);
  assign dbgState = state;
  // A flush in the same cycle as OK cancels the writeback
  assign wbFire   = busy && (fpuOutOK == OkOk) && !flush;

  // Command to the slave: the latched op while busy, otherwise a NOP
  assign fpuOpCmd = busy ? cmdQ   : NopCmd;
  assign fpuIdIxt = busy ? ixtQ   : 8'h00;
  assign fpuIds   = busy ? idsQ   : 18'h0;
  assign fpuValRs = busy ? valRsQ : 64'h0;
  assign fpuValRt = busy ? valRtQ : 64'h0;

  // Next-state decode; flush overrides every state
  always_comb begin
    stateNext = state;
    if (flush) begin
      stateNext = StIdle;
    end else begin
      case (state)
        StIdle:  if (reqValid) stateNext = StBusy;
        StBusy: begin
          case (fpuOutOK)
            OkOk, OkReady: stateNext = StIdle;
            OkHold:        stateNext = (holdCnt == TimeoutCnt) ? StFault : StBusy;
            OkFault:       stateNext = StFault;
            default:       stateNext = StIdle;
          endcase
        end
        StFault: stateNext = StFault;
        default: stateNext = StIdle;
      endcase
    end
  end

  // State register and the consecutive-HOLD counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= StIdle;
      holdCnt <= 4'd0;
    end else begin
      state <= stateNext;
      if (flush || accept) begin
        holdCnt <= 4'd0;
      end else if (busy && (fpuOutOK == OkHold) && (holdCnt != TimeoutCnt)) begin
        holdCnt <= holdCnt + 4'd1;
      end
    end
  end

  // Capture the request fields on the transfer edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmdQ   <= 8'h00;
      ixtQ   <= 8'h00;
      idsQ   <= 18'h0;
      valRsQ <= 64'h0;
      valRtQ <= 64'h0;
    end else if (accept) begin
      cmdQ   <= reqCmd;
      ixtQ   <= reqIxt;
      idsQ   <= reqIds;
      valRsQ <= reqValRs;
      valRtQ <= reqValRt;
    end
  end

  // Registered writeback: one-cycle pulse; the data holds until the next OK
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wbValid <= 1'b0;
      wbId    <= 6'h0;
      wbVal   <= 64'h0;
      wbSrT   <= 1'b0;
    end else begin
      wbValid <= wbFire;
      if (wbFire) begin
        wbId  <= fpuOutId;
        wbVal <= fpuOutVal;
        wbSrT <= fpuOutSrT;
      end
    end
  end

endmodule

// File: tb/tb_fpu_ex_issue.sv
// Bench for fpu_ex_issue: table of single-op vectors plus directed
// sequences for timeout, flush and reset-during-hold.
module tb_fpu_ex_issue;

  localparam logic [1:0] OK_READY = 2'd0;
  localparam logic [1:0] OK_OK    = 2'd1;
  localparam logic [1:0] OK_HOLD  = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic [7:0]  reqCmd;
  logic [7:0]  reqIxt;
  logic [17:0] reqIds;
  logic [63:0] reqValRs;
  logic [63:0] reqValRt;
  logic [7:0]  fpuOpCmd;
  logic [7:0]  fpuIdIxt;
  logic [17:0] fpuIds;
  logic [63:0] fpuValRs;
  logic [63:0] fpuValRt;
  logic [1:0]  fpuOutOK;
  logic [5:0]  fpuOutId;
  logic [63:0] fpuOutVal;
  logic        fpuOutSrT;
  logic        wbValid;
  logic [5:0]  wbId;
  logic [63:0] wbVal;
  logic        wbSrT;
  logic        flush;
  logic        fault;
  logic [1:0]  dbgState;

  fpu_ex_issue #(.TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqCmd(reqCmd), .reqIxt(reqIxt),
    .reqIds(reqIds), .reqValRs(reqValRs), .reqValRt(reqValRt),
    .fpuOpCmd(fpuOpCmd), .fpuIdIxt(fpuIdIxt), .fpuIds(fpuIds),
    .fpuValRs(fpuValRs), .fpuValRt(fpuValRt),
    .fpuOutOK(fpuOutOK), .fpuOutId(fpuOutId), .fpuOutVal(fpuOutVal), .fpuOutSrT(fpuOutSrT),
    .wbValid(wbValid), .wbId(wbId), .wbVal(wbVal), .wbSrT(wbSrT),
    .flush(flush), .fault(fault), .dbgState(dbgState)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every writeback pulse must match the oldest expected value
  always @(negedge clock) begin
    if (reset === 1'b1 && wbValid === 1'b1) begin
      if (exp_q.size() == 0) check("wb_unexpected", {63'h0, wbValid}, 64'h0);
      else check("wb_scoreboard", wbVal, exp_q.pop_front());
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  ixt;
    logic [17:0] ids;
    logic [63:0] rs;
    logic [63:0] rt;
    int          n_hold;
    logic [1:0]  final_ok;
    logic [5:0]  out_id;
    logic [63:0] out_val;
    logic        out_srt;
    logic        exp_wb;
    logic [5:0]  exp_id;
    logic [63:0] exp_val;
    logic        exp_srt;
  } vec_t;

  vec_t vecs[5];

  task automatic drive_idle();
    reqValid = 1'b0; reqCmd = 8'h00; reqIxt = 8'h00; reqIds = 18'h0;
    reqValRs = 64'h0; reqValRt = 64'h0;
    fpuOutOK = OK_READY; fpuOutId = 6'h0; fpuOutVal = 64'h0; fpuOutSrT = 1'b0;
    flush = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clock); #1;
    reqValid = 1'b1; reqCmd = v.cmd; reqIxt = v.ixt; reqIds = v.ids;
    reqValRs = v.rs; reqValRt = v.rt; fpuOutOK = OK_READY;
    @(negedge clock);
    check("accept_ready", {63'h0, reqReady}, 64'h1);
    @(posedge clock); #1;
    // Scramble the request inputs: the slave must see latched values only
    reqValid = 1'b0; reqCmd = ~v.cmd; reqIxt = ~v.ixt; reqIds = ~v.ids;
    reqValRs = ~v.rs; reqValRt = ~v.rt;
    if (v.exp_wb) exp_q.push_back(v.exp_val);
    for (int h = 0; h <= v.n_hold; h++) begin
      if (h < v.n_hold) begin
        fpuOutOK = OK_HOLD; fpuOutId = ~v.out_id; fpuOutVal = ~v.out_val; fpuOutSrT = ~v.out_srt;
      end else begin
        fpuOutOK = v.final_ok; fpuOutId = v.out_id; fpuOutVal = v.out_val; fpuOutSrT = v.out_srt;
      end
      @(negedge clock);
      check("busy_cmd", {56'h0, fpuOpCmd}, {56'h0, v.cmd});
      check("busy_ixt", {56'h0, fpuIdIxt}, {56'h0, v.ixt});
      check("busy_ids", {46'h0, fpuIds}, {46'h0, v.ids});
      check("busy_rs", fpuValRs, v.rs);
      check("busy_rt", fpuValRt, v.rt);
      check("busy_no_wb", {63'h0, wbValid}, 64'h0);
      @(posedge clock); #1;
    end
    fpuOutOK = OK_READY; fpuOutId = 6'h0; fpuOutVal = 64'h0; fpuOutSrT = 1'b0;
    @(negedge clock);
    check("wb_valid", {63'h0, wbValid}, {63'h0, v.exp_wb});
    check("wb_id", {58'h0, wbId}, {58'h0, v.exp_id});
    check("wb_val", wbVal, v.exp_val);
    check("wb_srt", {63'h0, wbSrT}, {63'h0, v.exp_srt});
    check("ready_after", {63'h0, reqReady}, 64'h1);
    check("nop_after", {56'h0, fpuOpCmd}, 64'h40);
  endtask

  // ---------------- main test ----------------
  initial begin
    // cmd, ixt, ids, rs, rt, n_hold, final_ok, out_id, out_val, out_srt, exp_wb, exp_id, exp_val, exp_srt
    vecs[0] = '{8'h05, 8'h00, 18'h12000, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                0, OK_OK, 6'h12, 64'h3FF0_0000_0000_0000, 1'b0,
                1'b1, 6'h12, 64'h3FF0_0000_0000_0000, 1'b0};
    vecs[1] = '{8'h0A, 8'h03, 18'h2A5C3, 64'hAAAA_0000_BBBB_0000, 64'h0000_CCCC_0000_DDDD,
                5, OK_OK, 6'h07, 64'h4000_0000_0000_0000, 1'b1,
                1'b1, 6'h07, 64'h4000_0000_0000_0000, 1'b1};
    vecs[2] = '{8'h45, 8'h11, 18'h01041, 64'h0123_0000_0000_0001, 64'h0000_0000_0000_0002,
                0, OK_READY, 6'h3F, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0,
                1'b0, 6'h07, 64'h4000_0000_0000_0000, 1'b1};
    vecs[3] = '{8'h81, 8'hF0, 18'h3FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                2, OK_READY, 6'h2B, 64'hCAFE_F00D_CAFE_F00D, 1'b0,
                1'b0, 6'h07, 64'h4000_0000_0000_0000, 1'b1};
    vecs[4] = '{8'hC3, 8'h5A, 18'h08421, 64'h0000_0000_0000_00FF, 64'h7FF0_0000_0000_0000,
                1, OK_OK, 6'h01, 64'h0123_4567_89AB_CDEF, 1'b0,
                1'b1, 6'h01, 64'h0123_4567_89AB_CDEF, 1'b0};

    // Reset values
    drive_idle();
    reset = 1'b0;
    @(negedge clock);
    check("rst_cmd", {56'h0, fpuOpCmd}, 64'h40);
    check("rst_ids", {46'h0, fpuIds}, 64'h0);
    check("rst_rs", fpuValRs, 64'h0);
    check("rst_wbvalid", {63'h0, wbValid}, 64'h0);
    check("rst_wbval", wbVal, 64'h0);
    check("rst_wbid", {58'h0, wbId}, 64'h0);
    check("rst_fault", {63'h0, fault}, 64'h0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Table-driven single ops
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Timeout: continuous HOLD, fault after 16 HOLD samples
    @(posedge clock); #1;
    reqValid = 1'b1; reqCmd = 8'h11; fpuOutOK = OK_HOLD;
    @(negedge clock);
    check("to_accept", {63'h0, reqReady}, 64'h1);
    @(posedge clock); #1;
    reqValid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      check("to_no_fault", {63'h0, fault}, 64'h0);
      check("to_cmd_stable", {56'h0, fpuOpCmd}, 64'h11);
      @(posedge clock); #1;
    end
    @(negedge clock);
    check("to_fault", {63'h0, fault}, 64'h1);
    check("to_not_ready", {63'h0, reqReady}, 64'h0);
    check("to_nop", {56'h0, fpuOpCmd}, 64'h40);
    @(posedge clock); #1;
    reqValid = 1'b1; reqCmd = 8'h12;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("fault_not_ready", {63'h0, reqReady}, 64'h0);
      check("fault_sticky", {63'h0, fault}, 64'h1);
      @(posedge clock); #1;
    end
    flush = 1'b1;
    @(negedge clock);
    check("flush_not_ready", {63'h0, reqReady}, 64'h0);
    @(posedge clock); #1;
    flush = 1'b0; reqValid = 1'b0; fpuOutOK = OK_READY;
    @(negedge clock);
    check("flush_clears_fault", {63'h0, fault}, 64'h0);
    check("flush_ready", {63'h0, reqReady}, 64'h1);
    check("flush_no_accept", {56'h0, fpuOpCmd}, 64'h40);

    // Flush in the same cycle OK is sampled
    @(posedge clock); #1;
    reqValid = 1'b1; reqCmd = 8'h22;
    @(negedge clock);
    check("fo_accept", {63'h0, reqReady}, 64'h1);
    @(posedge clock); #1;
    reqValid = 1'b0; fpuOutOK = OK_OK; fpuOutId = 6'h2E; fpuOutVal = 64'hBAD0_BAD0_BAD0_BAD0; flush = 1'b1;
    @(negedge clock);
    check("fo_busy_cmd", {56'h0, fpuOpCmd}, 64'h22);
    @(posedge clock); #1;
    flush = 1'b0; fpuOutOK = OK_READY;
    @(negedge clock);
    check("fo_no_wb", {63'h0, wbValid}, 64'h0);
    check("fo_wbval_kept", wbVal, 64'h0123_4567_89AB_CDEF);
    check("fo_idle", {56'h0, fpuOpCmd}, 64'h40);

    // Flush together with reqValid while idle
    @(posedge clock); #1;
    reqValid = 1'b1; reqCmd = 8'h23; flush = 1'b1;
    @(negedge clock);
    check("fr_not_ready", {63'h0, reqReady}, 64'h0);
    @(posedge clock); #1;
    reqValid = 1'b0; flush = 1'b0;
    @(negedge clock);
    check("fr_not_issued", {56'h0, fpuOpCmd}, 64'h40);

    // Reset pulsed during HOLD
    @(posedge clock); #1;
    reqValid = 1'b1; reqCmd = 8'h33; reqValRs = 64'h0000_1234_5678_0000; fpuOutOK = OK_HOLD;
    @(posedge clock); #1;
    reqValid = 1'b0;
    @(negedge clock);
    check("rh_busy_cmd", {56'h0, fpuOpCmd}, 64'h33);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("rh_cmd", {56'h0, fpuOpCmd}, 64'h40);
    check("rh_rs", fpuValRs, 64'h0);
    check("rh_wbval", wbVal, 64'h0);
    check("rh_wbvalid", {63'h0, wbValid}, 64'h0);
    check("rh_fault", {63'h0, fault}, 64'h0);
    @(posedge clock); #1;
    reset = 1'b1; fpuOutOK = OK_OK; fpuOutVal = 64'hFEED_FEED_FEED_FEED;
    reqValid = 1'b1; reqCmd = 8'h44;
    @(negedge clock);
    check("rh_ready", {63'h0, reqReady}, 64'h1);
    check("rh_no_wb", {63'h0, wbValid}, 64'h0);
    @(posedge clock); #1;
    reqValid = 1'b0; fpuOutId = 6'h15; fpuOutVal = 64'h4008_0000_0000_0000;
    exp_q.push_back(64'h4008_0000_0000_0000);
    @(negedge clock);
    check("rh_resume_cmd", {56'h0, fpuOpCmd}, 64'h44);
    @(posedge clock); #1;
    fpuOutOK = OK_READY;
    @(negedge clock);
    check("rh_resume_wb", {63'h0, wbValid}, 64'h1);
    check("rh_resume_id", {58'h0, wbId}, 64'h15);

    repeat (2) @(posedge clock);
    check("exp_q_drained", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpu_ex_issue.md
FPU_EX_ISSUE -- requirements
Module: fpu_ex_issue

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of consecutive HOLD cycles tolerated before a fault is raised (range 1..15).
REQ-002 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port reqValid, input, 1, the upstream FPU op is valid.
REQ-005 SHALL have port reqReady, output, 1, the op is accepted this cycle.
REQ-006 SHALL have port reqCmd, input, 8, FPU command: [7:6] condition code (00 AL, 01 NV, 10 CT, 11 CF), [5:0] opcode.
REQ-007 SHALL have port reqIxt, input, 8, index/opcode extension.
REQ-008 SHALL have port reqIds, input, 18, register IDs packed as {Rn,Rt,Rs}, 6 bits each.
REQ-009 SHALL have ports reqValRs and reqValRt, input, 64 each, operand values.
REQ-010 SHALL have ports fpuOpCmd (8), fpuIdIxt (8), fpuIds (18), fpuValRs (64) and fpuValRt (64), all outputs, the command driven to the FPU slave.
REQ-011 SHALL have port fpuOutOK, input, 2, FPU status: 0 READY, 1 OK, 2 HOLD, 3 FAULT.
REQ-012 SHALL have ports fpuOutId (input, 6), fpuOutVal (input, 64) and fpuOutSrT (input, 1), the FPU result.
REQ-013 SHALL have ports wbValid (output, 1), wbId (output, 6), wbVal (output, 64) and wbSrT (output, 1), the registered writeback.
REQ-014 SHALL have port flush, input, 1, synchronous cancel.
REQ-015 SHALL have port fault, output, 1, sticky fault flag.

Function
REQ-016 SHALL implement a state machine with states IDLE, BUSY and FAULT.
REQ-017 SHALL assert reqReady only in IDLE with flush=0.
REQ-018 SHALL, on reqValid&&reqReady, latch reqCmd, reqIxt, reqIds, reqValRs and reqValRt, clear holdCnt, and enter BUSY.
REQ-019 SHALL drive the fpu* outputs from the latched fields while in BUSY, holding them stable across HOLD cycles.
REQ-020 SHALL drive fpuOpCmd=8'h40 (NV, NOP) and all other fpu* outputs to 0 outside BUSY.
REQ-021 SHALL, in BUSY, sample fpuOutOK every cycle, starting with the first BUSY cycle.
REQ-022 SHALL, when BUSY samples OK, capture fpuOutId into wbId, fpuOutVal into wbVal and fpuOutSrT into wbSrT, pulse wbValid for exactly the next cycle, and return to IDLE.
REQ-023 SHALL, when BUSY samples READY (command not executed or disabled by its condition code), return to IDLE with no wbValid pulse and leave wbId, wbVal and wbSrT unchanged.
REQ-024 SHALL, when BUSY samples HOLD, stay in BUSY and increment the 4-bit holdCnt.
REQ-025 SHALL, when BUSY samples HOLD while holdCnt==TIMEOUT, enter FAULT instead of staying in BUSY.
REQ-026 SHALL, when BUSY samples FAULT, enter FAULT.
REQ-027 SHALL assert fault whenever the state is FAULT, and remain in FAULT until flush.
REQ-028 SHALL give a latency of: accept in cycle N, command on the fpu* outputs in N+1, and, if OK is sampled in N+1+k, wbValid in N+2+k.
REQ-029 SHALL, when flush=1 in any state, enter IDLE on the next cycle, clear holdCnt and fault, suppress any wbValid pulse due that cycle, and not accept a concurrent reqValid.
REQ-030 SHALL accept no new request in the cycle wbValid is high unless the state is IDLE; a back-to-back minimum spacing of 2 cycles per op is permitted.
REQ-031 SHALL not accept a request while in FAULT (reqReady=0).

Reset
REQ-032 SHALL, while reset=0, asynchronously force state=IDLE, holdCnt=0, all latched fields=0, fpuOpCmd=8'h40, all other fpu* outputs=0, wbValid=0, wbId=0, wbVal=0, wbSrT=0 and fault=0.
REQ-033 SHALL, if reset is asserted mid-operation (BUSY with HOLD pending), abandon the op with no writeback, and resume accepting requests on the first edge after reset deasserts.

Verification
REQ-034 SHALL be covered by: accept reqCmd=8'h05, Rn=6'h12 in cycle 0; fpuOutOK=OK in cycle 1 with fpuOutVal=64'h3FF0000000000000 and fpuOutId=6'h12 -> wbValid=1 in cycle 2 with wbVal=64'h3FF0000000000000 and wbId=6'h12; reqReady=1 again in cycle 2.
REQ-035 SHALL be covered by: fpuOutOK=HOLD for 5 cycles, then OK -> fpu* outputs stable for all 6 cycles; wbValid in the 7th cycle after the command appears.
REQ-036 SHALL be covered by: fpuOutOK held at HOLD with TIMEOUT=15 -> fault=1 after 16 HOLD samples; reqReady=0 until flush; fault=0 the cycle after flush.
REQ-037 SHALL be covered by: reqCmd=8'h45 (NV) with fpuOutOK=READY -> IDLE with no wbValid, and the previous wbVal retained.
REQ-038 SHALL be covered by: flush in the same cycle OK is sampled -> no wbValid; flush together with reqValid -> request not accepted.
REQ-039 SHALL be covered by: reset pulsed low during a HOLD -> all outputs return to their reset values immediately, with no wbValid after release.
